// File: rtl/mux_arb.sv
// mux_arb: N-channel valid/ready arbitrating mux with packet lock and one-stage output register
module mux_arb #(
    parameter int NUM_INPUTS = 6,
    parameter int DATA_WIDTH = 8,
    parameter int MODE       = 0,
    localparam int SEL_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [NUM_INPUTS-1:0]            i_valid,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
    input  logic [NUM_INPUTS-1:0]            i_last,
    output logic [NUM_INPUTS-1:0]            o_ready,
    output logic                             o_valid,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic                             o_last,
    output logic [SEL_W-1:0]                 o_grant,
    input  logic                             i_ready
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nx;
    logic [SEL_W-1:0] rr_ptr, lock_idx, start, sel;
    logic found, load, xfer;
    assign load  = !o_valid || i_ready;
    assign start = (MODE == 1) ? '0 : rr_ptr;
    always_comb begin
        int k;
        k     = 0;
        found = 1'b0;
        sel   = '0;
        if (state == LOCKED) begin
            sel   = lock_idx;
            found = i_valid[lock_idx];
        end else begin
            for (int j = 0; j < NUM_INPUTS; j++) begin
                k = int'(start) + j;
                if (k >= NUM_INPUTS) k = k - NUM_INPUTS;
                if (!found && i_valid[k]) begin
                    found = 1'b1;
                    sel   = SEL_W'(k);
                end
            end
        end
    end
    assign xfer    = found && load && !i_rst;
    assign o_ready = xfer ? NUM_INPUTS'(1) << sel : '0;
    always_comb begin
        state_nx = state;
        if (xfer) state_nx = i_last[sel] ? IDLE : LOCKED;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_last   <= 1'b0;
            o_grant  <= '0;
        end else begin
            state <= state_nx;
            if (xfer) begin
                if (i_last[sel]) rr_ptr <= (sel == SEL_W'(NUM_INPUTS - 1)) ? '0 : sel + 1'b1;
                else lock_idx <= sel;
                o_data  <= i_data_bus[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                o_last  <= i_last[sel];
                o_grant <= sel;
                o_valid <= 1'b1;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: table-driven checks of round-robin, lock, backpressure and reset, plus fixed-priority sequences
module tb_mux_arb;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, rdy;
    logic [5:0] valid, last;
    logic [47:0] bus = 48'hAABBCCDDEEFF;
    logic [5:0] ordy0, ordy1;
    logic ov0, ov1, ol0, ol1;
    logic [7:0] od0, od1;
    logic [2:0] og0, og1;
    int checks = 0, failures = 0;

    mux_arb #(.NUM_INPUTS(6), .DATA_WIDTH(8), .MODE(0)) u_rr (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data_bus(bus), .i_last(last),
        .o_ready(ordy0), .o_valid(ov0), .o_data(od0), .o_last(ol0), .o_grant(og0), .i_ready(rdy));
    mux_arb #(.NUM_INPUTS(6), .DATA_WIDTH(8), .MODE(1)) u_fp (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data_bus(bus), .i_last(last),
        .o_ready(ordy1), .o_valid(ov1), .o_data(od1), .o_last(ol1), .o_grant(og1), .i_ready(rdy));

    typedef struct {
        logic rst; logic [5:0] valid; logic [5:0] last; logic rdy;
        logic [5:0] ordy; logic ov; logic [7:0] od; logic ol; logic [2:0] og;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic r, input logic [5:0] va, input logic [5:0] la, input logic rd,
                       input logic [5:0] er, input logic ev, input logic [7:0] ed, input logic el,
                       input logic [2:0] eg);
        vec_t t;
        t.rst = r; t.valid = va; t.last = la; t.rdy = rd;
        t.ordy = er; t.ov = ev; t.od = ed; t.ol = el; t.og = eg;
        vq.push_back(t);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; valid = '0; last = '0; rdy = 1'b1;
        @(posedge clk); #1;
        add(1, 6'h3F, 6'h3F, 1, 6'h00, 0, 8'h00, 0, 0);
        add(1, 6'h3F, 6'h3F, 1, 6'h00, 0, 8'h00, 0, 0);
        add(0, 6'h3F, 6'h3F, 1, 6'h01, 1, 8'hFF, 1, 0);
        add(0, 6'h3F, 6'h3F, 1, 6'h02, 1, 8'hEE, 1, 1);
        add(0, 6'h3F, 6'h3F, 1, 6'h04, 1, 8'hDD, 1, 2);
        add(0, 6'h3F, 6'h3F, 1, 6'h08, 1, 8'hCC, 1, 3);
        add(0, 6'h3F, 6'h3F, 1, 6'h10, 1, 8'hBB, 1, 4);
        add(0, 6'h3F, 6'h3F, 1, 6'h20, 1, 8'hAA, 1, 5);
        add(0, 6'h3F, 6'h3F, 1, 6'h01, 1, 8'hFF, 1, 0);
        add(0, 6'h10, 6'h3F, 1, 6'h10, 1, 8'hBB, 1, 4);
        add(0, 6'h22, 6'h3F, 1, 6'h20, 1, 8'hAA, 1, 5);
        add(0, 6'h22, 6'h3F, 1, 6'h02, 1, 8'hEE, 1, 1);
        add(0, 6'h05, 6'h00, 1, 6'h04, 1, 8'hDD, 0, 2);
        add(0, 6'h05, 6'h00, 1, 6'h04, 1, 8'hDD, 0, 2);
        add(0, 6'h01, 6'h00, 1, 6'h00, 0, 8'hDD, 0, 2);
        add(0, 6'h05, 6'h04, 1, 6'h04, 1, 8'hDD, 1, 2);
        add(0, 6'h01, 6'h01, 1, 6'h01, 1, 8'hFF, 1, 0);
        add(0, 6'h00, 6'h00, 1, 6'h00, 0, 8'hFF, 1, 0);
        add(0, 6'h3F, 6'h3F, 0, 6'h02, 1, 8'hEE, 1, 1);
        for (int i = 0; i < 4; i++) add(0, 6'h3F, 6'h3F, 0, 6'h00, 1, 8'hEE, 1, 1);
        add(0, 6'h3F, 6'h3F, 1, 6'h04, 1, 8'hDD, 1, 2);
        add(0, 6'h3F, 6'h3F, 1, 6'h08, 1, 8'hCC, 1, 3);
        add(0, 6'h10, 6'h00, 1, 6'h10, 1, 8'hBB, 0, 4);
        add(1, 6'h3F, 6'h00, 1, 6'h00, 0, 8'h00, 0, 0);
        add(0, 6'h3F, 6'h3F, 1, 6'h01, 1, 8'hFF, 1, 0);
        foreach (vq[i]) begin
            rst = vq[i].rst; valid = vq[i].valid; last = vq[i].last; rdy = vq[i].rdy;
            #1;
            chk("o_ready", i, 32'(ordy0), 32'(vq[i].ordy));
            @(posedge clk); #1;
            chk("o_valid", i, 32'(ov0), 32'(vq[i].ov));
            chk("o_data", i, 32'(od0), 32'(vq[i].od));
            chk("o_last", i, 32'(ol0), 32'(vq[i].ol));
            chk("o_grant", i, 32'(og0), 32'(vq[i].og));
        end
        begin
            logic [5:0] rr_rdy [3];
            logic [2:0] rr_g [3];
            rr_rdy = '{6'h02, 6'h08, 6'h02};
            rr_g   = '{3'd1, 3'd3, 3'd1};
            valid = 6'h0A; last = 6'h0A; rdy = 1'b1; rst = 1'b0;
            for (int i = 0; i < 3; i++) begin
                #1;
                chk("fp_o_ready", i, 32'(ordy1), 32'h02);
                chk("rr_contrast_o_ready", i, 32'(ordy0), 32'(rr_rdy[i]));
                @(posedge clk); #1;
                chk("fp_o_grant", i, 32'(og1), 32'd1);
                chk("fp_o_data", i, 32'(od1), 32'hEE);
                chk("rr_contrast_o_grant", i, 32'(og0), 32'(rr_g[i]));
            end
        end
        last = 6'h00;
        #1;
        chk("fp_lock_o_ready", 0, 32'(ordy1), 32'h02);
        @(posedge clk); #1;
        chk("fp_lock_o_last", 0, 32'(ol1), 32'd0);
        valid = 6'h08;
        #1;
        chk("fp_lock_stall_o_ready", 1, 32'(ordy1), 32'h00);
        @(posedge clk); #1;
        chk("fp_lock_stall_o_valid", 1, 32'(ov1), 32'd0);
        valid = 6'h0A; last = 6'h02;
        #1;
        chk("fp_lock_resume_o_ready", 2, 32'(ordy1), 32'h02);
        @(posedge clk); #1;
        chk("fp_lock_resume_o_last", 2, 32'(ol1), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
